// File: rtl/mac_out_drain_pkg.sv
// Types and framing helper for mac_out_drain, built on the constants in mac_const.vh.
// Build option MAC_DRAIN_DBUF_EN (used by the importing modules) selects double buffering.
`include "mac_const.vh"

package mac_out_drain_pkg;

    typedef enum logic {
        DRAIN_IDLE = `MAC_DRAIN_IDLE,
        DRAIN_SEND = `MAC_DRAIN_SEND
    } drain_state_e;

    localparam int         DRAIN_BEATS = `MAC_DRAIN_BEATS;
    localparam logic [1:0] LAST_BEAT   = 2'(DRAIN_BEATS - 1);

    // A result spans 1, 2 or 4 lanes; unknown modes fall back to single-lane results.
    function automatic logic beat_is_last(input logic [1:0] mode, input logic [1:0] beat);
        case (mode)
            `MAC_DUAL: return beat[0];
            `MAC_QUAD: return beat == LAST_BEAT;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mac_const.vh
// Shared constants for the MAC drain path: framing modes, FSM encodings and beats per snapshot.
`ifndef MAC_CONST_VH
`define MAC_CONST_VH

`define MAC_SINGLE      2'd0
`define MAC_DUAL        2'd1
`define MAC_QUAD        2'd2

`define MAC_DRAIN_IDLE  1'b0
`define MAC_DRAIN_SEND  1'b1

`define MAC_DRAIN_BEATS 4

`endif

// File: rtl/mac_drain_snap.sv
// Snapshot storage for mac_out_drain: one entry by default, a two-entry FIFO when
// MAC_DRAIN_DBUF_EN is defined (then it also exposes the entry behind the head).
module mac_drain_snap #(
    parameter int ACC_W = 32
`ifdef MAC_DRAIN_DBUF_EN
    ,
    parameter int CONF_W = 3
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [3:0][ACC_W-1:0] push_data,
`ifdef MAC_DRAIN_DBUF_EN
    input  logic [CONF_W-1:0]     push_cfg,
    output logic [CONF_W-1:0]     nxt_cfg,
    output logic [ACC_W-1:0]      nxt_lane0,
`endif
    output logic [3:0][ACC_W-1:0] head_data,
    output logic                  full
);

`ifdef MAC_DRAIN_DBUF_EN
    logic [1:0][3:0][ACC_W-1:0] data_mem_q, data_mem_d;
    logic [1:0][CONF_W-1:0]     cfg_mem_q, cfg_mem_d;
    logic                       rd_ptr_q, rd_ptr_d;
    logic                       wr_ptr_q, wr_ptr_d;
    logic [1:0]                 count_q, count_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        data_mem_d = data_mem_q;
        cfg_mem_d  = cfg_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (push) begin
            data_mem_d[wr_ptr_q] = push_data;
            cfg_mem_d[wr_ptr_q]  = push_cfg;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        // A push and a pop in the same cycle leave the occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values together.
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
        // NOTE: payload storage is not reset; it is only ever read behind a nonzero count.
        data_mem_q <= data_mem_d;
        cfg_mem_q  <= cfg_mem_d;
    end

    assign head_data = data_mem_q[rd_ptr_q];
    assign nxt_cfg   = cfg_mem_q[~rd_ptr_q];
    assign nxt_lane0 = data_mem_q[~rd_ptr_q][0];
    assign full      = (count_q == 2'd2);
`else
    logic [3:0][ACC_W-1:0] data_q, data_d;
    logic                  full_q, full_d;

    always_comb begin
        data_d = push ? push_data : data_q;
        full_d = full_q;
        if (push) begin
            full_d = 1'b1;
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
        data_q <= data_d;
    end

    assign head_data = data_q;
    assign full      = full_q;
`endif

endmodule

// File: rtl/mac_out_drain.sv
// Snapshots the four MAC accumulator lanes and drains them as framed beats on a valid/ready stream.
// Define MAC_DRAIN_DBUF_EN for a two-entry snapshot buffer with bubble-free back-to-back drains.
module mac_out_drain
    import mac_out_drain_pkg::*;
#(
    parameter int MAC_CONF_WIDTH = 3,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_ACC_WIDTH  = 4 * MAC_MIN_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MAC_CONF_WIDTH-1:0] cfg,
    input  logic                      capture,
    input  logic [MAC_ACC_WIDTH-1:0]  in0,
    input  logic [MAC_ACC_WIDTH-1:0]  in1,
    input  logic [MAC_ACC_WIDTH-1:0]  in2,
    input  logic [MAC_ACC_WIDTH-1:0]  in3,
    output logic                      capture_ready,
    output logic [MAC_ACC_WIDTH-1:0]  out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [1:0]                out_lane,
    output logic                      out_last,
    output logic [MAC_CONF_WIDTH-1:0] out_cfg,
    input  logic                      clr_overrun,
    output logic                      overrun
);

    drain_state_e                   state_q, state_d;
    logic [1:0]                     beat_q, beat_d;
    logic [MAC_ACC_WIDTH-1:0]       out_data_q, out_data_d;
    logic                           out_last_q, out_last_d;
    logic [MAC_CONF_WIDTH-1:0]      out_cfg_q, out_cfg_d;
    logic                           overrun_q, overrun_d;

    logic [3:0][MAC_ACC_WIDTH-1:0]  lanes;
    logic [3:0][MAC_ACC_WIDTH-1:0]  head_data;
    logic                           snap_full;
    logic                           accept;
    logic                           fire;
    logic                           pop;
    logic [1:0]                     beat_nxt;
`ifdef MAC_DRAIN_DBUF_EN
    logic [MAC_CONF_WIDTH-1:0]      nxt_cfg;
    logic [MAC_ACC_WIDTH-1:0]       nxt_lane0;
`endif

    assign lanes         = {in3, in2, in1, in0};
    // The single-entry buffer is full exactly while sending, so this equals state == IDLE there.
    assign capture_ready = !snap_full;
    assign accept        = capture & capture_ready;
    assign out_valid     = (state_q == DRAIN_SEND);
    assign fire          = out_valid & out_ready;
    assign pop           = fire & (beat_q == LAST_BEAT);
    assign beat_nxt      = beat_q + 2'd1;

    mac_drain_snap #(
        .ACC_W     (MAC_ACC_WIDTH)
`ifdef MAC_DRAIN_DBUF_EN
        ,
        .CONF_W    (MAC_CONF_WIDTH)
`endif
    ) u_snap (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .pop       (pop),
        .push_data (lanes),
`ifdef MAC_DRAIN_DBUF_EN
        .push_cfg  (cfg),
        .nxt_cfg   (nxt_cfg),
        .nxt_lane0 (nxt_lane0),
`endif
        .head_data (head_data),
        .full      (snap_full)
    );

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        out_cfg_d  = out_cfg_q;
        overrun_d  = overrun_q;

        case (state_q)
            DRAIN_IDLE: begin
                // Beat 0 comes straight from the inputs; the snapshot supplies beats 1..3.
                if (accept) begin
                    state_d    = DRAIN_SEND;
                    beat_d     = 2'd0;
                    out_data_d = in0;
                    out_cfg_d  = cfg;
                    out_last_d = beat_is_last(cfg[1:0], 2'd0);
                end
            end
            DRAIN_SEND: begin
                if (fire && !pop) begin
                    beat_d     = beat_nxt;
                    out_data_d = head_data[beat_nxt];
                    out_last_d = beat_is_last(out_cfg_q[1:0], beat_nxt);
                end else if (pop) begin
                    state_d = DRAIN_IDLE;
                    beat_d  = 2'd0;
`ifdef MAC_DRAIN_DBUF_EN
                    // Chain into the buffered snapshot, or the one arriving this very cycle.
                    if (snap_full) begin
                        state_d    = DRAIN_SEND;
                        out_data_d = nxt_lane0;
                        out_cfg_d  = nxt_cfg;
                        out_last_d = beat_is_last(nxt_cfg[1:0], 2'd0);
                    end else if (accept) begin
                        state_d    = DRAIN_SEND;
                        out_data_d = in0;
                        out_cfg_d  = cfg;
                        out_last_d = beat_is_last(cfg[1:0], 2'd0);
                    end
`endif
                end
            end
            default: state_d = DRAIN_IDLE;
        endcase

        if (capture && !capture_ready) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DRAIN_IDLE;
            beat_q     <= 2'd0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_cfg_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            out_cfg_q  <= out_cfg_d;
            overrun_q  <= overrun_d;
        end
    end

    assign out_data = out_data_q;
    assign out_lane = beat_q;
    assign out_last = out_last_q;
    assign out_cfg  = out_cfg_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_mac_out_drain.sv
// Scoreboard bench for mac_out_drain: a reference model queues expected beats at capture time,
// and a negedge monitor compares them against every presented beat.
module tb_mac_out_drain;

`ifdef MAC_DRAIN_DBUF_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct {
        logic [31:0] data;
        logic [1:0]  lane;
        logic        last;
        logic [2:0]  cfg;
        logic        fin;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cfg;
    logic        capture;
    logic [31:0] in0, in1, in2, in3;
    logic        capture_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_lane;
    logic        out_last;
    logic [2:0]  out_cfg;
    logic        clr_overrun;
    logic        overrun;

    int    chk_cnt  = 0;
    int    pass_cnt = 0;
    beat_t exp_q[$];
    int    pending  = 0;
    logic  mdl_ovr  = 1'b0;
    bit    post_rst = 1'b0;

    always #5 clk = ~clk;

    mac_out_drain dut (
        .clk           (clk),
        .rst           (rst),
        .cfg           (cfg),
        .capture       (capture),
        .in0           (in0),
        .in1           (in1),
        .in2           (in2),
        .in3           (in3),
        .capture_ready (capture_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_lane      (out_lane),
        .out_last      (out_last),
        .out_cfg       (out_cfg),
        .clr_overrun   (clr_overrun),
        .overrun       (overrun)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Lanes per result: single = 1, dual = 2, quad = 4, unknown encodings count as single.
    function automatic int group_size(input logic [1:0] mode);
        if (mode == 2'd1) return 2;
        if (mode == 2'd2) return 4;
        return 1;
    endfunction

    // Reference model and monitor: everything sampled mid-cycle on the falling edge.
    always @(negedge clk) begin : monitor
        logic        mdl_ready;
        logic [31:0] ins [4];
        beat_t       e;
        beat_t       b;
        if (rst) begin
            exp_q.delete();
            pending  = 0;
            mdl_ovr  = 1'b0;
            post_rst = 1'b1;
        end else begin
            mdl_ready = (pending < CAP);
            if (post_rst)
                check("reset_state",
                      {out_valid, capture_ready, overrun, out_lane, out_last, out_cfg, out_data},
                      {1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 3'd0, 32'd0});
            post_rst = 1'b0;
            check("capture_ready", capture_ready, mdl_ready);
            check("overrun", overrun, mdl_ovr);
            check("out_valid", out_valid, exp_q.size() != 0);
            if (out_valid && exp_q.size() != 0) begin
                e = exp_q[0];
                check("beat", {out_data, out_lane, out_last, out_cfg},
                      {e.data, e.lane, e.last, e.cfg});
                if (out_ready) begin
                    if (e.fin) pending--;
                    void'(exp_q.pop_front());
                end
            end
            if (capture && mdl_ready) begin
                ins = '{in0, in1, in2, in3};
                for (int l = 0; l < 4; l++) begin
                    b.data = ins[l];
                    b.lane = 2'(l);
                    b.cfg  = cfg;
                    b.last = ((l + 1) % group_size(cfg[1:0])) == 0;
                    b.fin  = (l == 3);
                    exp_q.push_back(b);
                end
                pending++;
            end
            if (capture && !mdl_ready) mdl_ovr = 1'b1;
            else if (clr_overrun) mdl_ovr = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] d);
        in0 = a; in1 = b; in2 = c; in3 = d;
    endtask

    task automatic cap(input logic [2:0] m);
        cfg = m; capture = 1'b1;
        step();
        capture = 1'b0;
    endtask

    initial begin : driver
        logic [3:0] bp;
        bp          = 4'b1001;
        rst         = 1'b1;
        cfg         = 3'd0;
        capture     = 1'b0;
        out_ready   = 1'b1;
        clr_overrun = 1'b0;
        set_lanes(32'h0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single mode
        set_lanes(32'h11, 32'h22, 32'h33, 32'h44);
        cap(3'd0);
        repeat (6) step();

        // Dual, with cfg and lanes scrambled mid-drain
        cap(3'd1);
        cfg = 3'd6;
        set_lanes($urandom, $urandom, $urandom, $urandom);
        repeat (6) step();

        // Quad with accumulate tag set
        set_lanes(32'h11, 32'h22, 32'h33, 32'h44);
        cap(3'b110);
        cfg = 3'd0;
        repeat (6) step();

        // Backpressure 1,0,0,1 on an unknown mode encoding
        set_lanes(32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004);
        cap(3'd3);
        for (int i = 0; i < 16; i++) begin
            out_ready = bp[i % 4];
            step();
        end
        out_ready = 1'b1;
        repeat (3) step();

        // Overrun: captures stacked while stalled, then clear, then drop and clear together
        out_ready = 1'b0;
        capture   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_lanes($urandom, $urandom, $urandom, $urandom);
            cfg = 3'(i);
            step();
        end
        capture     = 1'b0;
        clr_overrun = 1'b1;
        step();
        capture = 1'b1;
        step();
        capture     = 1'b0;
        clr_overrun = 1'b0;
        step();
        out_ready = 1'b1;
        repeat (12) step();

        // Back-to-back captures two cycles apart
        set_lanes(32'h1, 32'h2, 32'h3, 32'h4);
        cap(3'd2);
        step();
        set_lanes(32'h5, 32'h6, 32'h7, 32'h8);
        cap(3'd1);
        repeat (10) step();

        // Reset mid-drain
        out_ready = 1'b0;
        cap(3'd0);
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            capture     = ($urandom_range(0, 99) < 30);
            cfg         = 3'($urandom);
            set_lanes($urandom, $urandom, $urandom, $urandom);
            out_ready   = ($urandom_range(0, 9) < 7);
            clr_overrun = ($urandom_range(0, 19) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            step();
        end

        // Drain
        rst         = 1'b0;
        capture     = 1'b0;
        clr_overrun = 1'b0;
        out_ready   = 1'b1;
        repeat (20) step();
        check("drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
